// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared mp4 types: cacheline geometry and memory arbiter enums.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_SERVE_I = 3'd1,
        ARB_SERVE_D = 3'd2,
        ARB_RESP_I  = 3'd3,
        ARB_RESP_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_req_t;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/cacheline_arbiter.sv
// ============================================================================
// Module      : cacheline_arbiter
// Description : Round-robin sharing of one cacheline memory port between the
//               icache and dcache, with a one-cycle registered response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_arbiter #(
    parameter int ADDR_WIDTH  = rv32i_types::ADDR_WIDTH,
    parameter int LINE_WIDTH  = rv32i_types::LINE_WIDTH,
    parameter int OFFSET_BITS = rv32i_types::OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    import rv32i_types::*;

    localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

    arb_state_t            state_q, state_d;
    arb_req_t              last_q,  last_d;
    logic [LINE_WIDTH-1:0] line_q,  line_d;

    logic                  w_i_req;
    logic                  w_d_req;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            last_q  <= ICACHE;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        line_d    = line_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        i_rdata   = '0;
        d_resp    = 1'b0;
        d_rdata   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                // Under contention the side that did not win last time goes next.
                if (w_i_req && (!w_d_req || last_q == DCACHE)) begin
                    state_d = ARB_SERVE_I;
                    last_d  = ICACHE;
                end else if (w_d_req) begin
                    state_d = ARB_SERVE_D;
                    last_d  = DCACHE;
                end
            end

            ARB_SERVE_I: begin
                mem_read = 1'b1;
                mem_addr = i_addr & C_ALIGN_MASK;
                if (mem_resp) begin
                    line_d  = mem_rdata;
                    state_d = ARB_RESP_I;
                end
            end

            ARB_SERVE_D: begin
                // A writeback takes priority if the dcache raises both lines.
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_addr  = d_addr & C_ALIGN_MASK;
                mem_wdata = d_wdata;
                if (mem_resp) begin
                    line_d  = mem_rdata;
                    state_d = ARB_RESP_D;
                end
            end

            ARB_RESP_I: begin
                i_resp  = 1'b1;
                i_rdata = line_q;
                state_d = ARB_IDLE;
            end

            ARB_RESP_D: begin
                d_resp  = 1'b1;
                d_rdata = line_q;
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule : cacheline_arbiter

`default_nettype wire
